// File: rtl/gpio_link_pkg.sv
// Shared definitions for the GPIO header byte link: pin map, FSM states,
// byte width and the even-parity helper.
`timescale 1ns/1ps
package gpio_link_pkg;

    localparam int BYTE_W        = 8;

    // Pin positions on the 40-pin header bus
    localparam int GPIO_DATA_LSB = 0;
    localparam int GPIO_PAR      = 8;
    localparam int GPIO_REQ      = 9;
    localparam int GPIO_ACK      = 10;

    // Number of header inputs that go through the synchronizers
    localparam int GPIO_SYNC_W   = GPIO_REQ + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rx_state_t;

    // Even parity over data and parity bit: XOR of all nine bits must be 0
    function automatic logic parity_good(input logic [BYTE_W-1:0] data, input logic par);
        return ~(^{data, par});
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small show-ahead FIFO. The head entry is held in a register so the
// consumer sees the oldest byte without a read request; the storage array
// has no reset and is only read through that register.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic [WIDTH-1:0] head_reg;
    logic             valid_reg;
    logic             full_reg;
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    rd_ptr_inc;

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // honoured when a pop frees a slot in the same cycle.
    assign do_pop     = pop && valid_reg;
    assign do_push    = push && (!full_reg || do_pop);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Storage array write port (no reset, maps onto block RAM)
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers, occupancy and registered status flags
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            full_reg   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            count_reg <= count_next;
            valid_reg <= (count_next != '0);
            full_reg  <= (count_next == CNT_FULL);
        end
    end

    // Head register: loads the incoming byte when it becomes the head,
    // otherwise the next stored entry after a pop; stale when drained.
    always_ff @(posedge clk) begin
        if (srst) begin
            head_reg <= '0;
        end else if (do_push && ((count_reg == '0) || (do_pop && count_reg == CNT_ONE))) begin
            head_reg <= push_data;
        end else if (do_pop && (count_reg > CNT_ONE)) begin
            head_reg <= mem[rd_ptr_inc];
        end
    end

    assign pop_data = head_reg;
    assign valid    = valid_reg;
    assign full     = full_reg;

endmodule

// File: rtl/gpio_handshake_rx.sv
// Receive side of the GPIO header byte link: synchronizes the header pins,
// runs the 4-phase REQ/ACK handshake, checks even parity, counts bytes and
// queues them for the display logic.
`timescale 1ns/1ps
module gpio_handshake_rx
    import gpio_link_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic [31:0]       gpio_in,
    output logic              gpio_ack,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic [15:0]       byte_count
);

    logic [GPIO_SYNC_W-1:0] sync_last;
    logic                   req_s;
    logic                   par_s;
    logic [BYTE_W-1:0]      data_s;

    rx_state_t              state_reg;
    logic                   ack_reg;
    logic                   perr_reg;
    logic [15:0]            byte_count_reg;
    logic                   fifo_full;
    logic                   push;
    logic                   unused_pins;

    // Header pins above REQ carry nothing for this receiver
    assign unused_pins = ^gpio_in[31:GPIO_SYNC_W];

    // Synchronizer chain, one register bank per stage
    genvar gi;
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic [GPIO_SYNC_W-1:0] stage_reg;
        if (gi == 0) begin : g_head
            // First stage samples the asynchronous pins
            always_ff @(posedge CLOCK_50) begin
                if (Reset) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= gpio_in[GPIO_SYNC_W-1:0];
                end
            end
        end else begin : g_tail
            // Later stages shift the previous stage along
            always_ff @(posedge CLOCK_50) begin
                if (Reset) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= g_sync[gi-1].stage_reg;
                end
            end
        end
    end

    assign sync_last = g_sync[SYNC_STAGES-1].stage_reg;
    assign req_s     = sync_last[GPIO_REQ];
    assign par_s     = sync_last[GPIO_PAR];
    assign data_s    = sync_last[GPIO_DATA_LSB +: BYTE_W];

    // Capture uses the registered full flag, so a capture that coincides
    // with a pop on a full FIFO simply slips by one cycle.
    assign push = (state_reg == IDLE) && req_s && !fifo_full;

    // Handshake FSM with parity flag and byte counter
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_reg      <= IDLE;
            ack_reg        <= 1'b0;
            perr_reg       <= 1'b0;
            byte_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (push) begin
                        state_reg      <= ACK;
                        ack_reg        <= 1'b1;
                        byte_count_reg <= byte_count_reg + 1'b1;
                        if (!parity_good(data_s, par_s)) begin
                            perr_reg <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    // Hold until REQ returns low so a byte is never taken twice
                    if (!req_s) begin
                        state_reg <= IDLE;
                        ack_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLOCK_50),
        .srst      (Reset),
        .push      (push),
        .push_data (data_s),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .valid     (rx_valid),
        .full      (fifo_full)
    );

    assign gpio_ack   = ack_reg;
    assign parity_err = perr_reg;
    assign byte_count = byte_count_reg;

endmodule
